// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a start/in_ready request side and an out_valid pulse.
// Ops 0-4 finish in one cycle. MUL is an iterative shift-add. SHL/SHR shift one
// bit per cycle. The result and the {Z,N,C,V} flags are registered and hold until
// the next completion.
module alu_mc #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic             start,
   output logic             in_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             out_valid
);

   localparam int CW = SHW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MUL   = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;

   localparam logic [3:0] OP_ZERO = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AINC = 4'd3;
   localparam logic [3:0] OP_B    = 4'd4;
   localparam logic [3:0] OP_MUL  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;

   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_WIDTH = CW'(WIDTH);

   logic [1:0]         state_q,  state_d;
   logic [2*WIDTH-1:0] acc_q,    acc_d;     // product accumulator; low half doubles as shift value
   logic [2*WIDTH-1:0] mcand_q,  mcand_d;   // multiplicand, moves left one place per iteration
   logic [WIDTH-1:0]   mplier_q, mplier_d;  // multiplier, consumed LSB first
   logic [CW-1:0]      cnt_q,    cnt_d;     // iterations remaining
   logic               dir_q,    dir_d;     // 1 = shift right
   logic [WIDTH-1:0]   result_q, result_d;
   logic [3:0]         flags_q,  flags_d;
   logic               valid_q,  valid_d;

   logic [WIDTH:0]     add_s, sub_s, inc_s;
   logic               add_v_s, sub_v_s, inc_v_s;
   logic               big_shift_s;
   logic [SHW-1:0]     shamt_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   sh_val_s;
   logic               sh_out_s;

   // Build the {Z,N,C,V} flag nibble for a completed result.
   function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                           input logic c, input logic v);
      mk_flags = {(r == {WIDTH{1'b0}}), r[WIDTH-1], c, v};
   endfunction

   // Single-cycle arithmetic. The extra top bit is the carry out, or the borrow for SUB.
   assign add_s   = {1'b0, a} + {1'b0, b};
   assign sub_s   = {1'b0, a} - {1'b0, b};
   assign inc_s   = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
   assign add_v_s = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
   assign sub_v_s = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
   assign inc_v_s = !a[WIDTH-1] && inc_s[WIDTH-1];

   // Any bit set above the count field means the shift empties the word.
   assign big_shift_s = |b[WIDTH-1:SHW];
   assign shamt_s     = b[SHW-1:0];

   // One shift-add step, and one single-bit shift step.
   assign prod_s   = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
   assign sh_val_s = dir_q ? {1'b0, acc_q[WIDTH-1:1]} : {acc_q[WIDTH-2:0], 1'b0};
   assign sh_out_s = dir_q ? acc_q[0] : acc_q[WIDTH-1];

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign result    = result_q;
   assign flags     = flags_q;
   assign out_valid = valid_q;

   // Next-state logic: accept requests in IDLE, then step the MUL and SHIFT iterations.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      result_d = result_q;
      flags_d  = flags_q;
      valid_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && in_ready) begin
               case (op)
                  OP_ZERO: begin
                     result_d = {WIDTH{1'b0}};
                     flags_d  = mk_flags({WIDTH{1'b0}}, 1'b0, 1'b0);
                     valid_d  = 1'b1;
                  end
                  OP_ADD: begin
                     result_d = add_s[WIDTH-1:0];
                     flags_d  = mk_flags(add_s[WIDTH-1:0], add_s[WIDTH], add_v_s);
                     valid_d  = 1'b1;
                  end
                  OP_SUB: begin
                     result_d = sub_s[WIDTH-1:0];
                     flags_d  = mk_flags(sub_s[WIDTH-1:0], sub_s[WIDTH], sub_v_s);
                     valid_d  = 1'b1;
                  end
                  OP_AINC: begin
                     result_d = inc_s[WIDTH-1:0];
                     flags_d  = mk_flags(inc_s[WIDTH-1:0], inc_s[WIDTH], inc_v_s);
                     valid_d  = 1'b1;
                  end
                  OP_B: begin
                     result_d = b;
                     flags_d  = mk_flags(b, 1'b0, 1'b0);
                     valid_d  = 1'b1;
                  end
                  OP_MUL: begin
                     acc_d    = {(2*WIDTH){1'b0}};
                     mcand_d  = {{WIDTH{1'b0}}, a};
                     mplier_d = b;
                     cnt_d    = CNT_WIDTH;
                     state_d  = S_MUL;
                  end
                  OP_SHL, OP_SHR: begin
                     if (big_shift_s) begin
                        result_d = {WIDTH{1'b0}};
                        flags_d  = mk_flags({WIDTH{1'b0}}, 1'b0, 1'b0);
                        valid_d  = 1'b1;
                     end else if (shamt_s == {SHW{1'b0}}) begin
                        result_d = a;
                        flags_d  = mk_flags(a, 1'b0, 1'b0);
                        valid_d  = 1'b1;
                     end else begin
                        acc_d   = {{WIDTH{1'b0}}, a};
                        dir_d   = (op == OP_SHR);
                        cnt_d   = {1'b0, shamt_s};
                        state_d = S_SHIFT;
                     end
                  end
                  default: begin
                     result_d = {WIDTH{1'b0}};
                     flags_d  = 4'b0000;
                     valid_d  = 1'b1;
                  end
               endcase
            end else begin
               valid_d = 1'b0;
            end
         end
         S_MUL: begin
            acc_d    = prod_s;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               result_d = prod_s[WIDTH-1:0];
               flags_d  = mk_flags(prod_s[WIDTH-1:0], |prod_s[2*WIDTH-1:WIDTH], 1'b0);
               valid_d  = 1'b1;
               state_d  = S_IDLE;
            end else begin
               state_d = S_MUL;
            end
         end
         S_SHIFT: begin
            acc_d = {{WIDTH{1'b0}}, sh_val_s};
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               result_d = sh_val_s;
               flags_d  = mk_flags(sh_val_s, sh_out_s, 1'b0);
               valid_d  = 1'b1;
               state_d  = S_IDLE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers. A synchronous reset also aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= {(2*WIDTH){1'b0}};
         mcand_q  <= {(2*WIDTH){1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         cnt_q    <= {CW{1'b0}};
         dir_q    <= 1'b0;
         result_q <= {WIDTH{1'b0}};
         flags_q  <= 4'b0000;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         valid_q  <= valid_d;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc. Directed vectors plus a randomized run, checked against an
// arithmetic reference model. A WIDTH=8 instance covers the narrow multiply.
module tb_alu_mc;

   logic        clk;
   logic        rst;
   logic [15:0] a, b;
   logic [3:0]  op;
   logic        start;
   logic        in_ready;
   logic [15:0] result;
   logic [3:0]  flags;
   logic        out_valid;

   logic [7:0]  a8, b8;
   logic [3:0]  op8;
   logic        start8;
   logic        in_ready8;
   logic [7:0]  result8;
   logic [3:0]  flags8;
   logic        out_valid8;

   int checks = 0;
   int errors = 0;

   logic [3:0]  bb_op  [4] = '{4'd0, 4'd3, 4'd4, 4'd2};
   logic [15:0] bb_a   [4] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h5678};
   logic [15:0] bb_b   [4] = '{16'h0000, 16'h0000, 16'h1234, 16'h1234};
   logic [15:0] bb_res [4] = '{16'h0000, 16'h0000, 16'h1234, 16'h4444};
   logic [3:0]  bb_flg [4] = '{4'b1000, 4'b1010, 4'b0000, 4'b0000};

   alu_mc #(.WIDTH(16)) u_dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start),
      .in_ready(in_ready), .result(result), .flags(flags), .out_valid(out_valid)
   );

   alu_mc #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .op(op8), .start(start8),
      .in_ready(in_ready8), .result(result8), .flags(flags8), .out_valid(out_valid8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model for WIDTH=16, written with plain integer arithmetic.
   function automatic void model(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                                 output logic [15:0] r, output logic [3:0] f, output int lat);
      longint ua, ub, full;
      int     sa, sb, s, n;
      logic   c, v;
      ua = longint'(av); ub = longint'(bv);
      sa = int'($signed(av)); sb = int'($signed(bv));
      c = 1'b0; v = 1'b0; lat = 1; full = 0;
      case (o)
         4'd1: begin
            full = ua + ub; c = (full >= 65536);
            s = sa + sb; v = (s > 32767) || (s < -32768);
         end
         4'd2: begin
            full = ua - ub + 65536; c = (ua < ub);
            s = sa - sb; v = (s > 32767) || (s < -32768);
         end
         4'd3: begin
            full = ua + 1; c = (full >= 65536);
            s = sa + 1; v = (s > 32767);
         end
         4'd4: full = ub;
         4'd5: begin
            full = ua * ub; c = (full >= 65536); lat = 17;
         end
         4'd6, 4'd7: begin
            if (ub >= 16) full = 0;
            else begin
               n = int'(ub);
               if (n == 0) full = ua;
               else if (o == 4'd6) begin
                  full = ua << n; c = ((ua >> (16 - n)) & 1) != 0; lat = n + 1;
               end else begin
                  full = ua >> n; c = ((ua >> (n - 1)) & 1) != 0; lat = n + 1;
               end
            end
         end
         default: full = 0;
      endcase
      r = 16'(full % 65536);
      f = (o >= 4'd8) ? 4'b0000 : {r == 16'h0000, r[15], c, v};
   endfunction

   // Issue one request from an idle cycle, scramble inputs after acceptance, and
   // check the latency, result and flags of the completion.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] av,
                         input logic [15:0] bv, input logic [15:0] er, input logic [3:0] ef,
                         input int el);
      int lat;
      chk({tag, "/rdy"}, 32'(in_ready), 32'd1);
      op = o; a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "/lat"}, 32'(lat), 32'(el));
      chk({tag, "/res"}, 32'(result), 32'(er));
      chk({tag, "/flg"}, 32'(flags), 32'(ef));
      chk({tag, "/rdy_done"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [3:0]  ro, rf;
      logic [15:0] ra, rb, rr;
      int          rl, pulses, first, lat8;

      rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; op = 4'h0;
      start8 = 1'b0; a8 = 8'h0; b8 = 8'h0; op8 = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst/res", 32'(result), 32'h0);
      chk("rst/flg", 32'(flags), 32'h0);
      chk("rst/ov", 32'(out_valid), 32'h0);
      chk("rst/rdy", 32'(in_ready), 32'h0);
      rst = 1'b0;
      #1;
      chk("rst/rdy_after", 32'(in_ready), 32'h1);

      // Single-cycle sweep
      run_op("add1", 4'd1, 16'h1234, 16'h5678, 16'h68AC, 4'b0000, 1);
      run_op("add2", 4'd1, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1);
      run_op("sub1", 4'd2, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110, 1);
      run_op("add3", 4'd1, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1);
      run_op("inv",  4'hF, 16'h1234, 16'h5678, 16'h0000, 4'b0000, 1);
      run_op("zero", 4'd0, 16'hABCD, 16'h1111, 16'h0000, 4'b1000, 1);

      // Back-to-back: start held four cycles
      for (int i = 0; i < 4; i++) begin
         op = bb_op[i]; a = bb_a[i]; b = bb_b[i]; start = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("b2b%0d/ov", i), 32'(out_valid), 32'd1);
         chk($sformatf("b2b%0d/res", i), 32'(result), 32'(bb_res[i]));
         chk($sformatf("b2b%0d/flg", i), 32'(flags), 32'(bb_flg[i]));
         chk($sformatf("b2b%0d/rdy", i), 32'(in_ready), 32'd1);
      end
      start = 1'b0;
      @(posedge clk); #1;
      chk("b2b/ov_end", 32'(out_valid), 32'd0);

      // Multiply
      run_op("mul1", 4'd5, 16'h00FF, 16'h0101, 16'hFFFF, 4'b0100, 17);
      run_op("mul2", 4'd5, 16'h1000, 16'h0010, 16'h0000, 4'b1010, 17);

      // Shifts
      run_op("shl1", 4'd6, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 2);
      run_op("shr1", 4'd7, 16'h8000, 16'h000F, 16'h0001, 4'b0000, 16);
      run_op("shlbig", 4'd6, 16'hFFFF, 16'h0010, 16'h0000, 4'b1000, 1);
      run_op("shr0", 4'd7, 16'hABCD, 16'h0000, 16'hABCD, 4'b0100, 1);

      // WIDTH=8 multiply
      chk("w8/rdy", 32'(in_ready8), 32'd1);
      op8 = 4'd5; a8 = 8'h0F; b8 = 8'h11; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat8 = 1;
      while (!out_valid8 && lat8 < 40) begin
         @(posedge clk); #1;
         lat8++;
      end
      chk("w8/lat", 32'(lat8), 32'd9);
      chk("w8/res", 32'(result8), 32'h0FF);
      chk("w8/flg", 32'(flags8), 32'b0100);

      // Busy: ADD requests during a MUL are ignored
      op = 4'd5; a = 16'h0003; b = 16'h0005; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      pulses = 0; first = 0;
      for (int cyc = 1; cyc <= 24; cyc++) begin
         if (out_valid) begin
            pulses++;
            if (first == 0) begin
               first = cyc;
               chk("busy/res", 32'(result), 32'h000F);
            end
         end
         if (cyc == 3) chk("busy/rdy", 32'(in_ready), 32'd0);
         if (cyc >= 3 && cyc <= 8) begin
            start = 1'b1; op = 4'd1; a = 16'h0001; b = 16'h0001;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      chk("busy/lat", 32'(first), 32'd17);
      chk("busy/pulses", 32'(pulses), 32'd1);

      // Reset in the middle of a MUL
      op = 4'd5; a = 16'h00FF; b = 16'h0101; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("rmid/rdy_rst", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("rmid/res", 32'(result), 32'h0);
      chk("rmid/flg", 32'(flags), 32'h0);
      chk("rmid/ov", 32'(out_valid), 32'h0);
      chk("rmid/rdy_hold", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("rmid/rdy_after", 32'(in_ready), 32'd1);
      pulses = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (out_valid) pulses++;
         @(posedge clk); #1;
      end
      chk("rmid/no_pulse", 32'(pulses), 32'd0);
      run_op("rmid/add", 4'd1, 16'h1234, 16'h5678, 16'h68AC, 4'b0000, 1);

      // Randomized run against the model
      for (int i = 0; i < 150; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = 16'($urandom);
         rb = (ro == 4'd6 || ro == 4'd7) ? 16'($urandom_range(0, 19)) : 16'($urandom);
         model(ro, ra, rb, rr, rf, rl);
         run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, rr, rf, rl);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the MU0 combinational ALU.
- Keeps op codes 0-4 (ZERO, ADD, SUB, A_INC, B) at 1-cycle latency.
- Adds iterative MUL, SHL and SHR, registered status flags, and a start/ready/valid handshake.
- Sits between the datapath register file and the accumulator write-back; the control unit stalls on in_ready/out_valid.

Parameters:
- WIDTH, 16, operand/result width (>=4, power of two).
- SHW, $clog2(WIDTH), width of shift-count field taken from b.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  operation code.
- start  in  1  request; accepted when start && in_ready.
- in_ready  out  1  block can accept a request this cycle.
- result  out  WIDTH  registered result; holds until next completion.
- flags  out  4  registered {Z,N,C,V}; holds with result.
- out_valid  out  1  one-cycle pulse: result/flags updated this cycle.

Behaviour:
Interface:
- One clock (clk); reset rst is synchronous and active-high.

Reset:
- result=0, flags=0, out_valid=0, state=IDLE.
- in_ready=0 while rst is high; in_ready=1 the first cycle after rst deasserts.
- rst mid-operation aborts the operation; no out_valid pulse follows.

States IDLE, MUL, SHIFT:
- in_ready = (state==IDLE) && !rst.

Accept:
- On an accept edge, a, b and op are latched; later input changes are ignored.
- start while in_ready=0 is ignored (no queuing).

Single-cycle ops (stay IDLE), result registered on the accept edge, out_valid high the following cycle (latency 1, throughput 1/cycle):
- 0 ZERO: result=0.
- 1 ADD: result=a+b mod 2^WIDTH.
- 2 SUB: result=a-b mod 2^WIDTH.
- 3 A_INC: result=a+1 mod 2^WIDTH.
- 4 B: result=b.
- 8-15 invalid: result=0, flags=0.

5 MUL (IDLE->MUL):
- Shift-add, one multiplier bit per cycle, WIDTH iterations.
- result = low WIDTH bits of a*b (unsigned).
- out_valid pulses exactly WIDTH+1 cycles after the accept edge; state returns to IDLE on the pulse edge.

6 SHL / 7 SHR (logical, IDLE->SHIFT):
- Shift count n = b[SHW-1:0], one bit per cycle; out_valid exactly n+1 cycles after accept.
- If b >= WIDTH: result=0, C=0, latency 1, no SHIFT entry.
- If n=0: result=a, C=0, latency 1.

Flags, updated only with out_valid:
- Z = (result==0).
- N = result[WIDTH-1].
- C:
  - ADD/A_INC: carry out.
  - SUB: borrow (a<b unsigned).
  - MUL: upper product half nonzero.
  - SHL/SHR: last bit shifted out.
  - else 0.
- V: two's-complement overflow for ADD, SUB and A_INC; 0 otherwise.

Back-to-back:
- in_ready is 1 in the cycle out_valid pulses (state already IDLE), so a new start is accepted that cycle.
- Its out_valid follows at its own latency.

Test Plan:
- WIDTH=16 single-cycle sweep: ADD 1234+5678 -> 68AC, flags 0000, out_valid 1 cycle after accept; ADD FFFF+0001 -> 0000, Z=1, C=1; SUB 0000-0001 -> FFFF, N=1, C=1; ADD 7FFF+0001 -> 8000, N=1, V=1; op=F -> 0000, flags 0000.
- Back-to-back: start held high 4 cycles with ops ZERO, A_INC(FFFF), B(1234), SUB(5678,1234) -> four consecutive out_valid pulses with results 0000, 0000 (C=1), 1234, 4444; in_ready stays 1 throughout.
- MUL 00FF*0101 -> FFFF, C=0, out_valid exactly 17 cycles after accept, in_ready=0 for 16 cycles; MUL 1000*0010 -> 0000, Z=1, C=1. Repeat at WIDTH=8: MUL 0F*11 -> FF after 9 cycles.
- Shifts: SHL 8001 by 1 -> 0002, C=1, latency 2; SHR 8000 by 15 -> 0001, latency 16; SHL by b=0010 (>=16) -> 0000, Z=1, latency 1; SHR by 0 -> a unchanged, latency 1.
- Busy/reset: during MUL assert start with ADD -> ignored, no extra out_valid. Assert rst at cycle 5 of a MUL -> no out_valid; result=0, flags=0, in_ready=0 during rst, in_ready=1 the next cycle; a fresh ADD then completes normally.
